fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the register-file/ALU/data-cache datapath. It owns the program counter and issues word requests to a synchronous instruction memory over a req/ready + rvalid handshake. Returned instructions go into a 2-entry buffer and are presented to decode with a valid/ready handshake. The stage also supplies PC+4 for the JAL/JALR link write (the datapath's newPC) and redirects on taken branch, JAL or JALR, using the datapath's eq flag and jalrOutput.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word requests to
// instruction memory, buffers up to two returned instructions and redirects on taken control flow.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic                  branch_en,
    input  logic                  eq,
    input  logic                  jal_en,
    input  logic                  jalr_en,
    input  logic [DATA_WIDTH-1:0] imm_op,
    input  logic [DATA_WIDTH-1:0] jalr_target
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] resp_pc;
    logic                  outstanding;
    logic                  discard;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head_instr, head_pc;
    logic [DATA_WIDTH-1:0] tail_instr, tail_pc;

    logic                  has_head;
    logic                  accept;
    logic                  rsp;
    logic                  pop;
    logic                  taken;
    logic                  push;
    logic                  outstanding_next;
    logic [DATA_WIDTH-1:0] target_raw;
    logic [DATA_WIDTH-1:0] target;

    assign has_head = (count != 2'd0);

    // At most one request in flight, and never more than the buffer can absorb.
    assign imem_req  = !rst && !outstanding && (({1'b0, count} + {2'b00, outstanding}) < {1'b0, DEPTH});
    assign imem_addr = fetch_pc;

    assign instr_valid = !rst && has_head;
    assign instr       = instr_valid ? head_instr : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign pc_plus4    = instr_valid ? head_pc + DATA_WIDTH'(4) : '0;

    assign accept = imem_req && imem_ready;
    assign rsp    = imem_rvalid && outstanding;
    assign pop    = instr_valid && instr_ready;
    assign taken  = pop && (jal_en || jalr_en || (branch_en && eq));

    assign target_raw = jalr_en ? (jalr_target & ~DATA_WIDTH'(1)) : head_pc + imm_op;
    assign target     = target_raw & ~DATA_WIDTH'(3);

    // A response arriving in a redirect cycle belongs to the abandoned path.
    assign push = rsp && !discard && !taken;

    assign outstanding_next = accept ? 1'b1 : (rsp ? 1'b0 : outstanding);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            count       <= 2'd0;
            head_instr  <= '0;
            head_pc     <= '0;
            tail_instr  <= '0;
            tail_pc     <= '0;
        end else begin
            outstanding <= outstanding_next;

            if (accept) begin
                resp_pc <= fetch_pc;
            end

            // A request accepted in the redirect cycle used the old PC, so target is not advanced.
            if (taken) begin
                fetch_pc <= target;
            end else if (accept) begin
                fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            end

            if (taken) begin
                discard <= outstanding_next;
            end else if (rsp && discard) begin
                discard <= 1'b0;
            end

            if (taken) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            head_instr <= imem_rdata;
                            head_pc    <= resp_pc;
                        end else begin
                            tail_instr <= imem_rdata;
                            tail_pc    <= resp_pc;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        count      <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head_instr <= imem_rdata;
                            head_pc    <= resp_pc;
                        end else begin
                            head_instr <= tail_instr;
                            head_pc    <= tail_pc;
                            tail_instr <= imem_rdata;
                            tail_pc    <= resp_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: startup vector table, directed redirect/stall/reset sequences,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic        branch_en, eq, jal_en, jalr_en;
    logic [31:0] imm_op, jalr_target;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .branch_en(branch_en), .eq(eq), .jal_en(jal_en), .jalr_en(jalr_en),
        .imm_op(imm_op), .jalr_target(jalr_target)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue of {instr, pc}, in-flight state is two flags.
    typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    bit          m_out = 0, m_disc = 0;
    logic [31:0] m_fpc = 32'h0, m_rpc = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    function automatic bit m_req();
        return !rst && !m_out && (mq.size() < 2);
    endfunction

    function automatic bit m_valid();
        return !rst && (mq.size() > 0);
    endfunction

    task automatic model_update();
        bit acc, rsp, pop, tk, nout;
        logic [31:0] hpc, tgt;
        if (rst) begin
            mq.delete(); m_out = 0; m_disc = 0; m_fpc = 32'h0; m_rpc = 32'h0;
            return;
        end
        acc = m_req() && imem_ready;
        rsp = imem_rvalid && m_out;
        pop = m_valid() && instr_ready;
        tk  = pop && (jal_en || jalr_en || (branch_en && eq));
        hpc = pop ? mq[0].pc : 32'h0;
        tgt = jalr_en ? jalr_target : hpc + imm_op;
        tgt[1:0] = 2'b00;
        nout = acc ? 1'b1 : (rsp ? 1'b0 : m_out);
        if (tk) begin
            mq.delete();
            m_disc = nout;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rsp) begin
                if (m_disc) m_disc = 0;
                else mq.push_back('{imem_rdata, m_rpc});
            end
        end
        if (acc) m_rpc = m_fpc;
        m_fpc = tk ? tgt : (acc ? m_fpc + 32'd4 : m_fpc);
        m_out = nout;
    endtask

    task automatic check_outputs();
        bit v;
        v = m_valid();
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        if (m_req()) chk("imem_addr", imem_addr, m_fpc);
        chk("instr_valid", 32'(instr_valid), 32'(v));
        chk("instr", instr, v ? mq[0].ins : 32'h0);
        chk("instr_pc", instr_pc, v ? mq[0].pc : 32'h0);
        chk("pc_plus4", pc_plus4, v ? mq[0].pc + 32'd4 : 32'h0);
    endtask

    // Behavioural memory: fixed or random latency, ready held low while busy.
    bit          auto_mem = 0;
    bit          mem_busy = 0;
    int          mem_due = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, spur_pct = 0;

    logic [31:0] delivered[$];
    logic [31:0] acc_addrs[$];
    int          acc_seen = 0;

    task automatic drive_mem();
        if (!auto_mem) return;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_due--;
            if (mem_due == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(mem_addr);
                mem_busy    = 0;
            end
        end else if (!m_out && $urandom_range(99) < spur_pct) begin
            imem_rvalid = 1'b1;
        end
        imem_ready = mem_busy ? 1'b0 : ($urandom_range(99) < ready_pct);
    endtask

    // Called right after a negedge with inputs set; ends at the next negedge.
    task automatic advance();
        bit macc;
        logic [31:0] maddr;
        if (instr_valid && instr_ready) delivered.push_back(instr_pc);
        if (imem_req && imem_ready) begin
            acc_addrs.push_back(imem_addr);
            acc_seen++;
        end
        macc  = m_req() && imem_ready;
        maddr = m_fpc;
        model_update();
        if (auto_mem && macc) begin
            mem_busy = 1;
            mem_due  = $urandom_range(lat_max, lat_min);
            mem_addr = maddr;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        drive_mem();
        #1;
        check_outputs();
        advance();
    endtask

    task automatic clear_ctl();
        branch_en = 0; eq = 0; jal_en = 0; jalr_en = 0;
        imm_op = 32'h0; jalr_target = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1; clear_ctl(); instr_ready = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_head(input string name, input logic [31:0] pc);
        int n = 0;
        while (!(m_valid() && mq[0].pc == pc) && n < 100) begin tick(); n++; end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_delivered(input string name, input int cnt);
        int n = 0;
        while (delivered.size() < cnt && n < 100) begin tick(); n++; end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    // Head 0x10 with the request for 0x14 still in flight.
    task automatic setup_head10();
        int n = 0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        wait_head("setup_head0_timeout", 32'h0);
        jal_en = 1; imm_op = 32'h10; instr_ready = 1;
        tick();
        clear_ctl(); instr_ready = 0;
        lat_min = 3; lat_max = 3;
        while (!(mq.size() == 1 && mq[0].pc == 32'h10 && m_out) && n < 100) begin tick(); n++; end
        chk("setup_head10_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic branch_case(input bit eqv, input logic [31:0] exp_next);
        setup_head10();
        delivered.delete();
        branch_en = 1; eq = eqv; imm_op = -32'sd8; instr_ready = 1;
        tick();
        clear_ctl();
        wait_delivered("branch_timeout", 2);
        if (delivered.size() >= 2) begin
            chk("branch_head_pc", delivered[0], 32'h10);
            chk("branch_next_pc", delivered[1], exp_next);
        end
    endtask

    typedef struct {
        bit rst; bit ready; bit rvalid; logic [31:0] rdata; bit iready;
        bit e_req; logic [31:0] e_addr; bit e_valid;
        logic [31:0] e_instr; logic [31:0] e_pc; logic [31:0] e_p4;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[1] = '{1, 0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[2] = '{0, 1, 0, 32'h0,         1, 1, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[3] = '{0, 1, 1, 32'h1111_0000, 1, 0, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[4] = '{0, 1, 0, 32'h0,         1, 1, 32'h4, 1, 32'h1111_0000, 32'h0, 32'h4};
        tbl[5] = '{0, 1, 1, 32'h2222_0004, 1, 0, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[6] = '{0, 1, 0, 32'h0,         1, 1, 32'h8, 1, 32'h2222_0004, 32'h4, 32'h8};
        tbl[7] = '{0, 1, 1, 32'h3333_0008, 1, 0, 32'h0, 0, 32'h0,         32'h0, 32'h0};
        tbl[8] = '{0, 0, 0, 32'h0,         1, 1, 32'hC, 1, 32'h3333_0008, 32'h8, 32'hC};
        tbl[9] = '{0, 0, 0, 32'h0,         1, 1, 32'hC, 0, 32'h0,         32'h0, 32'h0};

        rst = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 32'h0; instr_ready = 0;
        clear_ctl();
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; imem_ready = tbl[i].ready; imem_rvalid = tbl[i].rvalid;
            imem_rdata = tbl[i].rdata; instr_ready = tbl[i].iready;
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_plus4", i), pc_plus4, tbl[i].e_p4);
            check_outputs();
            advance();
        end

        // Decode stalled: exactly two fetches, then no request until drained.
        auto_mem = 1; lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset();
        acc_seen = 0;
        repeat (6) tick();
        chk("stall_accepts", 32'(acc_seen), 32'd2);
        chk("stall_req", 32'(imem_req), 32'd0);
        chk("stall_head_pc", instr_pc, 32'h0);
        delivered.delete();
        instr_ready = 1;
        wait_delivered("stall_timeout", 3);
        if (delivered.size() >= 3) begin
            chk("stall_pc0", delivered[0], 32'h0);
            chk("stall_pc1", delivered[1], 32'h4);
            chk("stall_pc2", delivered[2], 32'h8);
        end

        branch_case(1'b1, 32'h08);
        branch_case(1'b0, 32'h14);

        // JALR wins over JAL/branch; target bit 0 and bit 1 cleared.
        lat_min = 1; lat_max = 1;
        do_reset();
        wait_head("jalr_setup_timeout", 32'h0);
        jalr_en = 1; jal_en = 1; branch_en = 1; eq = 1; imm_op = 32'h40;
        jalr_target = 32'h123; instr_ready = 1;
        #1;
        chk("jalr_plus4", pc_plus4, 32'h4);
        #(-0);
        delivered.delete();
        advance_with_mem();
        clear_ctl();
        acc_addrs.delete();
        wait_delivered("jalr_timeout", 2);
        if (delivered.size() >= 2) chk("jalr_next_pc", delivered[1], 32'h120);
        if (acc_addrs.size() >= 1) chk("jalr_req_addr", acc_addrs[0], 32'h120);

        // Redirect in the cycle a response returns.
        do_reset();
        redirect_rvalid();
        // Redirect in the cycle a new request is accepted.
        do_reset();
        redirect_accept();

        // Reset with one buffered entry and a request in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        reset_midflight();

        // Randomized traffic.
        lat_min = 1; lat_max = 4; ready_pct = 70; spur_pct = 5;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(199) == 0);
            instr_ready = ($urandom_range(99) < 60);
            jalr_en     = ($urandom_range(99) < 5);
            jal_en      = ($urandom_range(99) < 5);
            branch_en   = ($urandom_range(99) < 20);
            eq          = $urandom_range(1);
            imm_op      = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(63) * 4) - 32'd128;
            jalr_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            tick();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic advance_with_mem();
        drive_mem();
        #1;
        check_outputs();
        advance();
    endtask

    task automatic redirect_rvalid();
        int n = 0;
        while (!(m_out && mem_busy && mem_due == 1 && mq.size() == 1) && n < 100) begin tick(); n++; end
        chk("redir_rvalid_setup_timeout", 32'(n < 100), 32'd1);
        delivered.delete();
        jal_en = 1; imm_op = 32'h40; instr_ready = 1;
        drive_mem();
        #1;
        chk("redir_rvalid_seen", 32'(imem_rvalid), 32'd1);
        check_outputs();
        advance();
        clear_ctl();
        wait_delivered("redir_rvalid_timeout", 2);
        if (delivered.size() >= 2) begin
            chk("redir_rvalid_head", delivered[0], 32'h0);
            chk("redir_rvalid_next", delivered[1], 32'h40);
        end
    endtask

    task automatic redirect_accept();
        int n = 0;
        while (!(m_req() && !mem_busy && mq.size() == 1) && n < 100) begin tick(); n++; end
        chk("redir_acc_setup_timeout", 32'(n < 100), 32'd1);
        delivered.delete();
        jal_en = 1; imm_op = 32'h80; instr_ready = 1;
        drive_mem();
        #1;
        chk("redir_acc_req", 32'(imem_req && imem_ready), 32'd1);
        check_outputs();
        advance();
        clear_ctl();
        acc_addrs.delete();
        wait_delivered("redir_acc_timeout", 2);
        if (delivered.size() >= 2) chk("redir_acc_next", delivered[1], 32'h80);
        if (acc_addrs.size() >= 1) chk("redir_acc_addr", acc_addrs[0], 32'h80);
    endtask

    task automatic reset_midflight();
        int n = 0;
        while (!(m_out && mq.size() == 1) && n < 100) begin tick(); n++; end
        chk("rst_setup_timeout", 32'(n < 100), 32'd1);
        rst = 1;
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst = 0;
        delivered.delete();
        acc_addrs.delete();
        instr_ready = 1;
        wait_delivered("rst_restart_timeout", 2);
        if (delivered.size() >= 2) begin
            chk("rst_first_pc", delivered[0], 32'h0);
            chk("rst_second_pc", delivered[1], 32'h4);
        end
        if (acc_addrs.size() >= 1) chk("rst_first_addr", acc_addrs[0], 32'h0);
        instr_ready = 0;
    endtask

endmodule
